// File: rtl/riscv_pkg.sv
// Shared core definitions: register file geometry, register file FSM states
// and the opcode constants decoded by register_file_mux.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    // Stack pointer gets a non-zero start value during the clear sequence
    localparam logic [REG_ADDR_W-1:0] REG_SP = 5'd2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/register_file_clear_seq.sv
// Post-reset initialisation sequencer: walks x1..x31 once, one register per
// edge, then reports the bank ready.
module register_file_clear_seq
    import riscv_pkg::rf_state_t, riscv_pkg::RF_CLEAR, riscv_pkg::RF_READY,
           riscv_pkg::REG_SP, riscv_pkg::REG_ADDR_W;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] STACK_INIT  = 32'h0000_1000,
    parameter logic [XLEN-1:0] RESET_VALUE = 32'h0
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    output logic                  o_clr_we,
    output logic [REG_ADDR_W-1:0] o_clr_addr,
    output logic [XLEN-1:0]       o_clr_data,
    output logic                  oREADY
);

    localparam logic [REG_ADDR_W-1:0] LastReg = {REG_ADDR_W{1'b1}};

    rf_state_t             state_q, state_d;
    logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;

    // Next state: advance the counter in CLEAR, hand over on the x31 write
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == RF_CLEAR) begin
            if (cnt_q == LastReg) begin
                state_d = RF_READY;
                cnt_d   = '0;
                ready_d = 1'b1;
            end else begin
                cnt_d   = cnt_q + 5'd1;
                ready_d = 1'b0;
            end
        end
    end

    // State, counter and registered ready flag; reset restarts the walk at x1
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= RF_CLEAR;
            cnt_q   <= 5'd1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Clear-side write port; held off while reset is asserted
    always_comb begin
        o_clr_we   = (state_q == RF_CLEAR) && !iRST;
        o_clr_addr = cnt_q;
        o_clr_data = (cnt_q == REG_SP) ? STACK_INIT : RESET_VALUE;
    end

    assign oREADY = ready_q;

endmodule

// File: rtl/register_file_bank.sv
// Architectural integer register file: 32 x XLEN, two asynchronous read
// ports, one synchronous write port, x0 hardwired to zero, optional bypass.
module register_file_bank
    import riscv_pkg::REG_COUNT, riscv_pkg::REG_ADDR_W;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] STACK_INIT  = 32'h0000_1000,
    parameter logic [XLEN-1:0] RESET_VALUE = 32'h0,
    parameter bit              BYPASS      = 1'b1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iWE,
    input  logic [REG_ADDR_W-1:0] i_RD,
    input  logic [REG_ADDR_W-1:0] i_RS1,
    input  logic [REG_ADDR_W-1:0] i_RS2,
    input  logic [XLEN-1:0]       i_REG_IN,
    output logic [XLEN-1:0]       o_REG_OUT1,
    output logic [XLEN-1:0]       o_REG_OUT2,
    output logic                  oREADY
);

    logic [XLEN-1:0]       regs_q [REG_COUNT];
    logic                  clr_we;
    logic [REG_ADDR_W-1:0] clr_addr;
    logic [XLEN-1:0]       clr_data;
    logic                  ready;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;

    register_file_clear_seq #(
        .XLEN        (XLEN),
        .STACK_INIT  (STACK_INIT),
        .RESET_VALUE (RESET_VALUE)
    ) u_clear_seq (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr),
        .o_clr_data (clr_data),
        .oREADY     (ready)
    );

    // Write source select: the sequencer owns the port until ready; user
    // writes during CLEAR are dropped, and x0 writes are discarded
    always_comb begin
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = clr_data;
        end else begin
            wr_en   = ready && !iRST && iWE && (i_RD != '0);
            wr_addr = i_RD;
            wr_data = i_REG_IN;
        end
    end

    // Register array; no reset, contents come from the clear sequence
    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Read ports: zero until ready and for x0, bypass same-cycle writes
    always_comb begin
        o_REG_OUT1 = '0;
        o_REG_OUT2 = '0;
        if (ready && (i_RS1 != '0)) begin
            o_REG_OUT1 = (BYPASS && iWE && (i_RS1 == i_RD)) ? i_REG_IN : regs_q[i_RS1];
        end
        if (ready && (i_RS2 != '0)) begin
            o_REG_OUT2 = (BYPASS && iWE && (i_RS2 == i_RD)) ? i_REG_IN : regs_q[i_RS2];
        end
    end

    assign oREADY = ready;

endmodule

// File: tb/tb_register_file_bank.sv
// Bench for register_file_bank: one bypassing and one non-bypassing instance
// share stimulus; expected read data is queued per cycle and checked at negedge.
module tb_register_file_bank;

    localparam logic [31:0] StackInit = 32'h0000_1000;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iWE  = 1'b0;
    logic [4:0]  i_RD = '0, i_RS1 = '0, i_RS2 = '0;
    logic [31:0] i_REG_IN = '0;
    logic [31:0] out1_b, out2_b, out1_n, out2_n;
    logic        ready_b, ready_n;

    always #5 iCLK = ~iCLK;

    register_file_bank #(.BYPASS(1'b1)) u_dut_byp (
        .iCLK(iCLK), .iRST(iRST), .iWE(iWE), .i_RD(i_RD), .i_RS1(i_RS1), .i_RS2(i_RS2),
        .i_REG_IN(i_REG_IN), .o_REG_OUT1(out1_b), .o_REG_OUT2(out2_b), .oREADY(ready_b)
    );

    register_file_bank #(.BYPASS(1'b0)) u_dut_nobyp (
        .iCLK(iCLK), .iRST(iRST), .iWE(iWE), .i_RD(i_RD), .i_RS1(i_RS1), .i_RS2(i_RS2),
        .i_REG_IN(i_REG_IN), .o_REG_OUT1(out1_n), .o_REG_OUT2(out2_n), .oREADY(ready_n)
    );

    typedef struct {
        logic [31:0] e1b, e2b, e1n, e2n;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void reset_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[2] = StackInit;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] rs, input bit byp);
        if (rs == 5'd0) return 32'h0;
        if (byp && iWE && (rs == i_RD)) return i_REG_IN;
        return model[rs];
    endfunction

    // One ready-state cycle: drive, queue expectations, check, then commit write
    task automatic cycle(input logic w, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                         input logic [4:0] a_rs2, input logic [31:0] d);
        exp_t e;
        iWE = w; i_RD = a_rd; i_RS1 = a_rs1; i_RS2 = a_rs2; i_REG_IN = d;
        e.e1b = exp_rd(a_rs1, 1'b1);
        e.e2b = exp_rd(a_rs2, 1'b1);
        e.e1n = exp_rd(a_rs1, 1'b0);
        e.e2n = exp_rd(a_rs2, 1'b0);
        sb_q.push_back(e);
        @(negedge iCLK);
        e = sb_q.pop_front();
        check_eq("rd1_byp", out1_b, e.e1b);
        check_eq("rd2_byp", out2_b, e.e2b);
        check_eq("rd1_nobyp", out1_n, e.e1n);
        check_eq("rd2_nobyp", out2_n, e.e2n);
        @(posedge iCLK);
        #1;
        if (w && (a_rd != 5'd0)) model[a_rd] = d;
        iWE = 1'b0;
    endtask

    // Release reset and count edges until ready; optional write at edge drop_at
    task automatic run_clear(input int drop_at, output int ready_at);
        ready_at = 0;
        iRST = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (e == drop_at) begin
                iWE = 1'b1; i_RD = 5'd3; i_REG_IN = 32'hAAAA_AAAA;
            end else begin
                iWE = 1'b0;
            end
            @(posedge iCLK);
            #1;
            if (ready_b && ready_n) begin
                ready_at = e;
                break;
            end
        end
        iWE = 1'b0;
        reset_model();
    endtask

    int ready_at;

    initial begin
        reset_model();
        repeat (3) @(posedge iCLK);
        #1;
        i_RS1 = 5'd2; i_RS2 = 5'd1;
        @(negedge iCLK);
        check_eq("rst_ready", {31'b0, ready_b}, 32'h0);
        check_eq("rst_rd1", out1_b, 32'h0);
        check_eq("rst_rd2", out2_n, 32'h0);
        @(posedge iCLK);
        #1;

        run_clear(10, ready_at);
        check_eq("init_latency", ready_at, 31);

        cycle(1'b0, 5'd0, 5'd2, 5'd1, 32'h0);
        cycle(1'b0, 5'd0, 5'd31, 5'd3, 32'h0);
        cycle(1'b1, 5'd5, 5'd5, 5'd6, 32'hDEAD_BEEF);
        cycle(1'b0, 5'd0, 5'd5, 5'd6, 32'h0);
        cycle(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
        cycle(1'b0, 5'd0, 5'd0, 5'd5, 32'h0);
        cycle(1'b1, 5'd7, 5'd7, 5'd7, 32'h1234_5678);
        cycle(1'b0, 5'd0, 5'd7, 5'd7, 32'h0);
        for (int i = 0; i < 24; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
        end

        // Reset in ready, then abort the clear at edge 20 with another reset
        cycle(1'b1, 5'd9, 5'd9, 5'd2, 32'h0000_0055);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        repeat (19) @(posedge iCLK);
        #1;
        check_eq("midclr_ready", {31'b0, ready_b}, 32'h0);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        check_eq("midclr_rst_ready", {31'b0, ready_n}, 32'h0);
        run_clear(0, ready_at);
        check_eq("reinit_latency", ready_at, 31);
        cycle(1'b0, 5'd0, 5'd9, 5'd2, 32'h0);
        cycle(1'b0, 5'd0, 5'd5, 5'd7, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
